mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/cpu_pkg.sv | 13 +
 rtl/mem_ctrl.sv | 101 ++++++++++
 tb/tb_mem_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types: memory-controller FSM state encoding and counter sizing.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } mem_state_e;

  localparam int unsigned WAIT_CNT_W = 4;

endpackage

// File: rtl/mem_ctrl.sv
// CPU-to-RAM bridge: latches one request, strobes the RAM once, waits out its
// latency and reports completion (or an illegal-access fault) via ready.
module mem_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_rd,
  input  logic                  mem_wr,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  ready,
  output logic                  fault,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);

  mem_state_e            state, state_next;
  logic                  armed;
  logic [WAIT_CNT_W-1:0] cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic                  is_wr;
  logic                  fault_q;

  logic [31:0] addr_high;
  logic        illegal;
  logic        accept;
  logic        enter_done_access;

  assign addr_high = addr >> (ADDR_WIDTH + 2);
  assign illegal   = (addr[1:0] != 2'b00) || (addr_high != 32'd0) || (mem_rd && mem_wr);
  assign accept    = (state == IDLE) && armed && (mem_rd || mem_wr);
  assign enter_done_access = ((state == ACCESS) && (WAIT_STATES == 0)) ||
                             ((state == WAIT) && (cnt == WAIT_CNT_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = illegal ? DONE : ACCESS;
      ACCESS:  state_next = (WAIT_STATES == 0) ? DONE : WAIT;
      WAIT:    if (cnt == WAIT_CNT_W'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch, wait counter and read-data capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed   <= 1'b1;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      is_wr   <= 1'b0;
      fault_q <= 1'b0;
      rdata   <= '0;
    end else begin
      // An idle-low sample re-arms even in DONE, so a dropped level is never missed
      if (!mem_rd && !mem_wr)  armed <= 1'b1;
      else if (state == DONE)  armed <= 1'b0;

      if (accept) begin
        addr_q  <= addr[ADDR_WIDTH+1:2];
        wdata_q <= wdata;
        is_wr   <= mem_wr;
        fault_q <= illegal;
        if (illegal && mem_rd) rdata <= '0;
      end

      if (state == ACCESS)    cnt <= WAIT_LOAD;
      else if (state == WAIT) cnt <= cnt - WAIT_CNT_W'(1);

      if (enter_done_access && !is_wr) rdata <= ram_rdata;
    end
  end

  always_comb begin
    ready     = (state == IDLE) || (state == DONE);
    fault     = (state == DONE) && fault_q;
    ram_cs    = (state == ACCESS);
    ram_we    = (state == ACCESS) && is_wr;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus pushes expected completions and RAM
// strobes; monitors pop and compare whenever the DUT presents them.
`timescale 1ns/1ps
module tb_mem_ctrl;
  localparam int AW = 16;
  localparam int WS = 2;

  logic          clk;
  logic          rst_n;
  logic          mem_rd, mem_wr;
  logic [31:0]   addr, wdata, rdata;
  logic          ready, fault;
  logic          ram_cs, ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;

  mem_ctrl #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .fault(fault),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [31:0] w);
    if (w == 32'd4) return 32'hDEADBEEF;
    return (w * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // Behavioural RAM attached to the DUT
  logic [31:0] ram_mem   [0:(1<<AW)-1];
  bit          ram_valid [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_cs && ram_we) begin
      ram_mem[ram_addr]   <= ram_wdata;
      ram_valid[ram_addr] <= 1'b1;
    end
  end
  always_comb begin
    ram_rdata = init_val(32'(ram_addr));
    if (ram_valid[ram_addr]) ram_rdata = ram_mem[ram_addr];
  end

  // Reference model state
  logic [31:0] mdl_mem [int unsigned];
  logic [31:0] mdl_rdata;

  typedef struct { bit flt; logic [31:0] rd; int low; } exp_t;
  typedef struct { bit we; logic [31:0] wa; logic [31:0] wd; } ram_t;
  exp_t exp_q[$];
  ram_t ram_q[$];

  int checks;
  int failures;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] mdl_read(input int unsigned w);
    if (mdl_mem.exists(w)) return mdl_mem[w];
    return init_val(w);
  endfunction

  // Model: legality, data effect and expected handshake length of one request
  task automatic model_req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    ram_t r;
    int unsigned w;
    bit bad;
    bad = (a % 4 != 0) || ((a >> (AW + 2)) != 0) || (rd && wr);
    w = (a / 4) % (1 << AW);
    if (bad) begin
      if (rd) mdl_rdata = 32'd0;
      e.flt = 1'b1; e.low = 0;
    end else begin
      if (wr) mdl_mem[w] = d;
      else    mdl_rdata = mdl_read(w);
      e.flt = 1'b0; e.low = 1 + WS;
      r.we = wr; r.wa = w; r.wd = d;
      ram_q.push_back(r);
    end
    e.rd = mdl_rdata;
    exp_q.push_back(e);
  endtask

  task automatic do_req(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input int hold, input int gap);
    int n;
    model_req(rd, wr, a, d);
    mem_rd = rd; mem_wr = wr; addr = a; wdata = d;
    @(posedge clk); #1;
    n = 0;
    while (!ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) chk("ready_timeout", 32'd0, 32'd1);
    repeat (1 + hold) begin @(posedge clk); #1; end
    mem_rd = 1'b0; mem_wr = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  // Completion monitor
  int low_cnt;
  initial begin
    exp_t e;
    low_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) low_cnt = 0;
      else if (ready && (low_cnt > 0 || fault)) begin
        if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("fault", 32'(fault), 32'(e.flt));
          chk("rdata", rdata, e.rd);
          chk("ready_low_cycles", 32'(low_cnt), 32'(e.low));
        end
        low_cnt = 0;
      end else if (!ready) low_cnt++;
    end
  end

  // RAM strobe monitor
  initial begin
    ram_t r;
    forever begin
      @(negedge clk);
      if (ram_cs) begin
        if (ram_q.size() == 0) chk("unexpected_ram_cs", 32'd1, 32'd0);
        else begin
          r = ram_q.pop_front();
          chk("ram_we", 32'(ram_we), 32'(r.we));
          chk("ram_addr", 32'(ram_addr), r.wa);
          if (r.we) chk("ram_wdata", ram_wdata, r.wd);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    int k;
    checks = 0; failures = 0;
    mdl_rdata = 32'd0;
    rst_n = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; addr = '0; wdata = '0;
    #3;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_ram_cs", 32'(ram_cs), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    do_req(1'b1, 1'b0, 32'h10, 32'h0, 0, 1);
    do_req(1'b0, 1'b1, 32'h8, 32'h12345678, 0, 1);
    do_req(1'b1, 1'b0, 32'h8, 32'h0, 0, 1);
    do_req(1'b1, 1'b0, 32'h6, 32'h0, 0, 1);
    do_req(1'b1, 1'b1, 32'h10, 32'hA5A5A5A5, 0, 1);
    do_req(1'b1, 1'b0, 32'h40000, 32'h0, 0, 1);
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 6, 1);
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 0, 1);

    for (int i = 0; i < 60; i++) begin
      k = int'($urandom_range(0, 9));
      a = 32'($urandom_range(0, 15)) << 2;
      case (k)
        0: do_req(1'b1, 1'b0, a | 32'($urandom_range(1, 3)), $urandom, int'($urandom_range(0, 3)), int'($urandom_range(1, 2)));
        1: do_req(1'b0, 1'b1, a | (32'd1 << $urandom_range(18, 31)), $urandom, int'($urandom_range(0, 3)), int'($urandom_range(1, 2)));
        2: do_req(1'b1, 1'b1, a, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(1, 2)));
        3, 4, 5: do_req(1'b0, 1'b1, a, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(1, 2)));
        default: do_req(1'b1, 1'b0, a, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(1, 2)));
      endcase
    end

    // Reset in the second WAIT cycle of a write aborts it without completion
    ram_q.push_back('{we: 1'b1, wa: 32'd5, wd: 32'hCAFEF00D});
    mem_wr = 1'b1; addr = 32'h14; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midwait_ready", 32'(ready), 32'd0);
    rst_n = 1'b0;
    #1;
    mdl_rdata = 32'd0;
    mdl_mem[5] = 32'hCAFEF00D;
    chk("abort_ram_cs", 32'(ram_cs), 32'd0);
    chk("abort_ram_we", 32'(ram_we), 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_rdata", rdata, 32'd0);
    chk("abort_ram_wdata", ram_wdata, 32'd0);
    mem_wr = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("post_abort_ready", 32'(ready), 32'd1);
      chk("post_abort_fault", 32'(fault), 32'd0);
    end
    do_req(1'b1, 1'b0, 32'h14, 32'h0, 0, 1);

    repeat (5) @(posedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("ram_q_drained", 32'(ram_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
